// File: rtl/pc_sequencer_if.sv
// Branch-request / fetch-address bus between decode logic (master) and the
// next-PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int AW = 9
);
  logic          br_valid;
  logic [2:0]    br_type;
  logic [AW-1:0] br_target;
  logic          cond_flag;
  logic [AW-1:0] pc;
  logic          fetch_valid;
  logic          jmp;

  modport master (
    output br_valid, br_type, br_target, cond_flag,
    input  pc, fetch_valid, jmp
  );

  modport slave (
    input  br_valid, br_type, br_target, cond_flag,
    output pc, fetch_valid, jmp
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, jumps, call/return via a small
// return-address stack, halt/resume and stall handling.
module pc_sequencer #(
  parameter int            AW        = 9,
  parameter logic [AW-1:0] RESET_VEC = {AW{1'b0}},
  parameter int            RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         halt,
  input  logic         resume,
  pc_sequencer_if.slave bus,
  output logic         ras_overflow,
  output logic         ras_underflow,
  output logic         illegal_br
);
  localparam int            IW       = $clog2(RAS_DEPTH);
  localparam int            CW       = IW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s, pc_inc_s, pc_rel_s;
  logic          jmp_r, jmp_nxt_s, fv_r;
  logic [AW-1:0] ras_r [RAS_DEPTH];
  logic [CW-1:0] count_r;
  logic [IW-1:0] push_idx_s, pop_idx_s;
  logic          push_s, pop_s, ovf_set_s, unf_set_s, ill_set_s;
  logic          ovf_r, unf_r, ill_r;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:1], 1'b0};
  endfunction

  assign pc_inc_s   = pc_r + AW'(2'd2);
  assign pc_rel_s   = pc_r + bus.br_target;
  // A full stack wraps the low index bits to 0, so top-of-stack is still idx-1.
  assign push_idx_s = count_r[IW-1:0];
  assign pop_idx_s  = push_idx_s - IW'(1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = ST_BOOT;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN:  state_nxt_s = halt   ? ST_HALT : ST_RUN;
      ST_HALT: state_nxt_s = resume ? ST_RUN  : ST_HALT;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Next PC, redirect flag and RAS/flag side effects
  always_comb begin
    pc_nxt_s  = pc_r;
    jmp_nxt_s = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    ill_set_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt || stall) begin
          pc_nxt_s = pc_r;
        end else if (bus.br_valid) begin
          pc_nxt_s = pc_inc_s;
          case (bus.br_type)
            3'b000: pc_nxt_s = pc_inc_s;
            3'b001: begin
              pc_nxt_s  = align(bus.br_target);
              jmp_nxt_s = 1'b1;
            end
            3'b010: begin
              if (bus.cond_flag) begin
                pc_nxt_s  = align(bus.br_target);
                jmp_nxt_s = 1'b1;
              end else begin
                pc_nxt_s  = pc_inc_s;
              end
            end
            3'b011: begin
              pc_nxt_s  = align(pc_rel_s);
              jmp_nxt_s = 1'b1;
            end
            3'b100: begin
              if (count_r == RAS_FULL) begin
                ovf_set_s = 1'b1;
              end else begin
                push_s    = 1'b1;
              end
              pc_nxt_s  = align(bus.br_target);
              jmp_nxt_s = 1'b1;
            end
            3'b101: begin
              if (count_r == {CW{1'b0}}) begin
                unf_set_s = 1'b1;
                pc_nxt_s  = pc_inc_s;
              end else begin
                pop_s     = 1'b1;
                pc_nxt_s  = align(ras_r[pop_idx_s]);
                jmp_nxt_s = 1'b1;
              end
            end
            default: ill_set_s = 1'b1;
          endcase
        end else begin
          pc_nxt_s = pc_inc_s;
        end
      end
      ST_HALT: begin
        if (resume) begin
          pc_nxt_s = pc_inc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: pc_nxt_s = pc_r;
    endcase
  end

  // Registered PC, outputs, RAS and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= RESET_VEC;
      jmp_r   <= 1'b0;
      fv_r    <= 1'b0;
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      ill_r   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= {AW{1'b0}};
      end
    end else begin
      pc_r  <= pc_nxt_s;
      jmp_r <= jmp_nxt_s;
      fv_r  <= (state_nxt_s == ST_RUN);
      ovf_r <= ovf_r | ovf_set_s;
      unf_r <= unf_r | unf_set_s;
      ill_r <= ill_r | ill_set_s;
      if (push_s) begin
        ras_r[push_idx_s] <= pc_inc_s;
        count_r           <= count_r + CW'(1'b1);
      end else if (pop_s) begin
        count_r           <= count_r - CW'(1'b1);
      end else begin
        count_r           <= count_r;
      end
    end
  end

  assign bus.pc          = pc_r;
  assign bus.fetch_valid = fv_r;
  assign bus.jmp         = jmp_r;
  assign ras_overflow    = ovf_r;
  assign ras_underflow   = unf_r;
  assign illegal_br      = ill_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// call/return and reset sequences, and random traffic against a queue-based model.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst, stall, halt, resume;
  logic ras_overflow, ras_underflow, illegal_br;

  pc_sequencer_if #(.AW(9)) bus();

  pc_sequencer #(.AW(9), .RESET_VEC(9'd0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .bus(bus), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .illegal_br(illegal_br)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=boot 1=run 2=halt, RAS as a queue.
  int m_pc, m_mode;
  bit m_jmp, m_fv, m_ovf, m_unf, m_ill;
  int m_ras[$];

  typedef struct {
    bit r, s, h, res, bv;
    int bt, tgt;
    bit cf;
    int e_pc;
    bit e_jmp, e_fv;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void model_step(bit r, bit s, bit h, bit res, bit bv, int bt, int tgt, bit cf);
    int nxt, disp;
    if (r) begin
      m_pc = 0; m_mode = 0; m_jmp = 0; m_fv = 0;
      m_ovf = 0; m_unf = 0; m_ill = 0;
      m_ras.delete();
      return;
    end
    m_jmp = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      if (res) begin
        m_mode = 1;
        m_pc = (m_pc + 2) % 512;
      end
    end else if (h) begin
      m_mode = 2;
    end else if (!s) begin
      nxt = (m_pc + 2) % 512;
      if (bv) begin
        case (bt)
          1: begin nxt = tgt & 32'h1FE; m_jmp = 1; end
          2: if (cf) begin nxt = tgt & 32'h1FE; m_jmp = 1; end
          3: begin
            disp = (tgt >= 256) ? tgt - 512 : tgt;
            nxt = ((m_pc + disp + 512) % 512) & 32'h1FE;
            m_jmp = 1;
          end
          4: begin
            if (m_ras.size() < 4) m_ras.push_back((m_pc + 2) % 512);
            else m_ovf = 1;
            nxt = tgt & 32'h1FE;
            m_jmp = 1;
          end
          5: begin
            if (m_ras.size() > 0) begin nxt = m_ras.pop_back(); m_jmp = 1; end
            else m_unf = 1;
          end
          6, 7: m_ill = 1;
          default: ;
        endcase
      end
      m_pc = nxt;
    end
    m_fv = (m_mode == 1);
  endfunction

  task automatic step(input bit r, input bit s, input bit h, input bit res, input bit bv,
                      input int bt, input int tgt, input bit cf);
    rst = r; stall = s; halt = h; resume = res;
    bus.br_valid = bv; bus.br_type = 3'(bt); bus.br_target = 9'(tgt); bus.cond_flag = cf;
    model_step(r, s, h, res, bv, bt, tgt, cf);
    @(posedge clk);
    #1;
    chk("pc", int'(bus.pc), m_pc);
    chk("jmp", int'(bus.jmp), int'(m_jmp));
    chk("fetch_valid", int'(bus.fetch_valid), int'(m_fv));
    chk("ras_overflow", int'(ras_overflow), int'(m_ovf));
    chk("ras_underflow", int'(ras_underflow), int'(m_unf));
    chk("illegal_br", int'(illegal_br), int'(m_ill));
  endtask

  function automatic void add(bit r, bit s, bit h, bit res, bit bv, int bt, int tgt, bit cf,
                              int e_pc, bit e_jmp, bit e_fv);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.res = res; v.bv = bv; v.bt = bt; v.tgt = tgt; v.cf = cf;
    v.e_pc = e_pc; v.e_jmp = e_jmp; v.e_fv = e_fv;
    tbl.push_back(v);
  endfunction

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input int bt, input int tgt, input bit cf);
    step(0, 0, 0, 0, 1, bt, tgt, cf);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
    bus.br_valid = 1'b0; bus.br_type = 3'd0; bus.br_target = 9'd0; bus.cond_flag = 1'b0;

    //   r  s  h  res bv bt  tgt     cf   pc     jmp fv
    add(1, 0, 0, 0, 0, 0, 0,      0,   0,      0,  0);
    add(1, 0, 0, 0, 0, 0, 0,      0,   0,      0,  0);
    add(0, 0, 0, 0, 0, 0, 0,      0,   0,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   2,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   4,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   6,      0,  1);
    add(0, 1, 0, 0, 1, 1, 'h40,   0,   6,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   8,      0,  1);
    add(0, 0, 0, 0, 1, 1, 'h40,   0,   'h40,   1,  1);
    add(0, 0, 0, 0, 1, 2, 'h80,   0,   'h42,   0,  1);
    add(0, 0, 0, 0, 1, 2, 'h80,   1,   'h80,   1,  1);
    add(0, 0, 0, 0, 1, 1, 'h41,   0,   'h40,   1,  1);
    add(0, 0, 0, 0, 1, 1, 'h20,   0,   'h20,   1,  1);
    add(0, 0, 0, 0, 1, 3, 'h1F0,  0,   'h10,   1,  1);
    add(0, 0, 0, 0, 1, 1, 'h1FE,  0,   'h1FE,  1,  1);
    add(0, 0, 0, 0, 1, 3, 4,      0,   'h002,  1,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   4,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   6,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   8,      0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   10,     0,  1);
    add(0, 0, 1, 0, 0, 0, 0,      0,   10,     0,  0);
    add(0, 1, 1, 0, 1, 1, 'h40,   0,   10,     0,  0);
    add(0, 0, 1, 1, 0, 0, 0,      0,   12,     0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   14,     0,  1);
    add(0, 0, 1, 1, 0, 0, 0,      0,   14,     0,  0);
    add(0, 0, 0, 1, 0, 0, 0,      0,   16,     0,  1);
    add(0, 0, 0, 0, 1, 6, 'h80,   0,   18,     0,  1);
    add(0, 0, 0, 0, 1, 1, 'h1FC,  0,   'h1FC,  1,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   'h1FE,  0,  1);
    add(0, 0, 0, 0, 0, 0, 0,      0,   0,      0,  1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].res, tbl[i].bv, tbl[i].bt, tbl[i].tgt, tbl[i].cf);
      chk($sformatf("vec%0d_pc", i), int'(bus.pc), tbl[i].e_pc);
      chk($sformatf("vec%0d_jmp", i), int'(bus.jmp), int'(tbl[i].e_jmp));
      chk($sformatf("vec%0d_fv", i), int'(bus.fetch_valid), int'(tbl[i].e_fv));
    end
    chk("illegal_sticky", int'(illegal_br), 1);

    // Call nesting four deep, overflow on the fifth, then unwind past empty.
    br(1, 'h10, 0);
    br(4, 'h30, 0);
    br(4, 'h50, 0);
    br(4, 'h70, 0);
    br(4, 'h100, 0);
    chk("call4_pc", int'(bus.pc), 'h100);
    chk("call4_no_ovf", int'(ras_overflow), 0);
    br(4, 'h120, 0);
    chk("call5_pc", int'(bus.pc), 'h120);
    chk("call5_jmp", int'(bus.jmp), 1);
    chk("call5_ovf", int'(ras_overflow), 1);
    br(5, 0, 0); chk("ret1_pc", int'(bus.pc), 'h72);
    br(5, 0, 0); chk("ret2_pc", int'(bus.pc), 'h52);
    br(5, 0, 0); chk("ret3_pc", int'(bus.pc), 'h32);
    br(5, 0, 0); chk("ret4_pc", int'(bus.pc), 'h12);
    chk("ret4_no_unf", int'(ras_underflow), 0);
    br(5, 0, 0);
    chk("ret5_pc", int'(bus.pc), 'h14);
    chk("ret5_jmp", int'(bus.jmp), 0);
    chk("ret5_unf", int'(ras_underflow), 1);

    // Reset while halted with two RAS entries and all flags set.
    br(4, 'h40, 0);
    br(4, 'h60, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("halt_fv", int'(bus.fetch_valid), 0);
    step(1, 1, 1, 0, 1, 1, 'h80, 0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_fv", int'(bus.fetch_valid), 0);
    chk("rst_ovf", int'(ras_overflow), 0);
    chk("rst_unf", int'(ras_underflow), 0);
    chk("rst_ill", int'(illegal_br), 0);
    idle();
    chk("boot_run_pc", int'(bus.pc), 0);
    chk("boot_run_fv", int'(bus.fetch_valid), 1);
    br(5, 0, 0);
    chk("post_rst_ret_pc", int'(bus.pc), 2);
    chk("post_rst_ret_unf", int'(ras_underflow), 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 511)), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the instruction fetch path. Owns the 9-bit program counter, which advances by 2 per fetch.
- Sequences the PC for reset, stall, halt/resume, absolute/relative/conditional jumps, and call/return through an internal return-address stack (RAS).
- Sits between the decode/branch logic and instruction memory. Its `pc` output is the fetch address.

Parameters:
- AW, 9, PC width in bits.
- RESET_VEC, 9'd0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold PC this cycle; branch request ignored.
- halt  input  1  enter HALT state.
- resume  input  1  leave HALT state.
- br_valid  input  1  branch request valid this cycle.
- br_type  input  3  000 none, 001 JMP abs, 010 JZ abs if cond_flag, 011 JREL, 100 CALL abs, 101 RET, 11x illegal.
- br_target  input  AW  absolute target, or signed two's-complement displacement for JREL.
- cond_flag  input  1  condition for JZ (1 = taken).
- pc  output  AW  current fetch address (registered).
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- jmp  output  1  registered; 1 for the cycle in which pc holds a redirected (non-sequential) value.
- ras_overflow  output  1  sticky: CALL issued with RAS full.
- ras_underflow  output  1  sticky: RET issued with RAS empty.
- illegal_br  output  1  sticky: br_valid with br_type 11x.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VEC; state=BOOT; fetch_valid=0, jmp=0.
  - RAS emptied; all sticky flags cleared.
  - rst overrides every other input, including mid-halt and mid-stall.
- States:
  - BOOT: one cycle, pc held. Goes to RUN unconditionally; fetch_valid=1 from the RUN cycle onward.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, pc held, branch and stall inputs ignored. resume=1 → RUN next cycle, pc continues from the held value.
- Priority in RUN: halt > stall > branch > increment.
  - halt=1 → HALT, pc held. halt wins over resume when both are high in RUN; resume wins when both are high in HALT.
  - stall=1 → pc held, jmp=0, br_valid ignored. The requester must hold the request until stall drops.
- Sequential step: pc ← pc+2, modulo 2^AW. 510 wraps to 0 with AW=9. jmp=0.
- Branch (br_valid=1, no stall):
  - JMP: pc ← br_target.
  - JZ: pc ← br_target if cond_flag=1, else pc+2.
  - JREL: pc ← pc + br_target, modulo 2^AW, with br_target sign-extended.
  - CALL: push pc+2 (modulo), then pc ← br_target.
  - RET: pc ← popped value.
  - Bit 0 of every computed redirect target is forced to 0.
  - jmp=1 only when the redirect is taken; a not-taken JZ gives jmp=0.
- Latency: branch request at cycle N → new pc visible after posedge N+1. No branch delay slot.
- RAS: RAS_DEPTH-entry LIFO with a count register.
  - CALL when full: push dropped, jump still taken, ras_overflow←1.
  - RET when empty: pc ← pc+2, jmp=0, ras_underflow←1.
- Illegal br_type: treated as a sequential step; illegal_br←1.
- Sticky flags clear only on rst.

Test Plan:
- Reset then free-run: rst high 2 cycles, then low → pc=0 for the BOOT cycle with fetch_valid=0, then 0,2,4,6 with fetch_valid=1. Run to pc=510 → next pc=0.
- JMP/JZ: at pc=8 issue JMP 0x40 → pc=0x40, jmp=1 for one cycle. JZ 0x80 with cond_flag=0 → 0x42, jmp=0. JZ 0x80 with cond_flag=1 → 0x80. JMP target 0x41 → 0x40.
- JREL: at pc=0x20 with br_target=9'h1F0 (−16) → 0x10. At pc=0x1FE with +4 → 0x002.
- CALL/RET nesting: CALLs at pcs 0x10, 0x30, 0x50, 0x70 (4 deep), then a 5th CALL → ras_overflow=1. Four RETs return to 0x72, 0x52, 0x32, 0x12. A 5th RET → pc+2, ras_underflow=1.
- Stall/halt: stall together with a JMP at pc=6 → pc stays 6 and the branch is ignored. Halt at pc=10 → pc holds 10, fetch_valid=0. halt+resume in HALT → RUN, pc 12.
- Reset mid-operation: rst during HALT with 2 RAS entries and flags set → pc=RESET_VEC, BOOT, RAS empty, flags 0. A subsequent RET → underflow.
